// File: rtl/sram_queue_64x16.sv
// FIFO built on an external single-read/single-write SRAM macro, with a two-entry
// output buffer that hides the one-cycle macro read latency.
module sram_queue_64x16 #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 3)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,

    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,

    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,

    output logic [CW-1:0]    count,

    output logic             sram_r_en,
    output logic [AW-1:0]    sram_r_addr,
    input  logic [WIDTH-1:0] sram_r_data,

    output logic             sram_w_en,
    output logic [AW-1:0]    sram_w_addr,
    output logic [WIDTH-1:0] sram_w_data,
    output logic             sram_w_mask
);

    localparam logic [AW:0] SRAM_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wptr, wptr_nxt;
    logic [AW-1:0]    rptr, rptr_nxt;
    logic [AW:0]      sram_cnt, sram_cnt_nxt;
    logic [1:0]       obuf_cnt, obuf_cnt_nxt;
    logic [1:0]       obuf_left;
    logic             inflight;
    logic [WIDTH-1:0] obuf_q   [2];
    logic [WIDTH-1:0] obuf_nxt [2];

    logic enq_fire;
    logic deq_fire;
    logic rd_issue;
    logic capture;

    always_comb begin
        enq_ready = (sram_cnt < SRAM_FULL) && !flush;
        deq_valid = (obuf_cnt != 2'd0) && !flush;
        deq_bits  = obuf_q[0];

        enq_fire  = enq_valid && enq_ready;
        deq_fire  = deq_valid && deq_ready;
        capture   = inflight && !flush;

        // A read is allowed if the buffer slot it will land in is guaranteed free,
        // counting the pop happening this cycle; this keeps streaming bubble-free.
        obuf_left = obuf_cnt - {1'b0, deq_fire};
        rd_issue  = (sram_cnt != '0) && !flush
                    && ((obuf_left + {1'b0, inflight}) < 2'd2);

        wptr_nxt     = wptr + AW'(enq_fire);
        rptr_nxt     = rptr + AW'(rd_issue);
        sram_cnt_nxt = sram_cnt + (AW+1)'(enq_fire) - (AW+1)'(rd_issue);

        obuf_nxt[0] = obuf_q[0];
        obuf_nxt[1] = obuf_q[1];
        if (deq_fire) begin
            obuf_nxt[0] = obuf_q[1];
        end
        if (capture) begin
            obuf_nxt[obuf_left[0]] = sram_r_data;
        end
        obuf_cnt_nxt = obuf_left + {1'b0, capture};

        count = CW'(sram_cnt) + CW'(obuf_cnt) + CW'(inflight);
    end

    assign sram_w_en   = enq_fire;
    assign sram_w_addr = wptr;
    assign sram_w_data = enq_bits;
    assign sram_w_mask = 1'b1;

    assign sram_r_en   = rd_issue;
    assign sram_r_addr = rptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            sram_cnt <= '0;
            obuf_cnt <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            sram_cnt <= '0;
            obuf_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            sram_cnt <= sram_cnt_nxt;
            obuf_cnt <= obuf_cnt_nxt;
            inflight <= rd_issue;
        end
    end

    // Buffer payload needs no reset: it is only visible when obuf_cnt says so.
    always_ff @(posedge clock) begin
        obuf_q[0] <= obuf_nxt[0];
        obuf_q[1] <= obuf_nxt[1];
    end

endmodule

// File: tb/tb_sram_queue_64x16.sv
// Directed and randomised checks of sram_queue_64x16 against a transaction
// scoreboard, with a behavioural model of the SRAM macro.
module tb_sram_queue_64x16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [15:0] enq_bits = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [15:0] deq_bits;
    logic [6:0]  count;
    logic        sram_r_en;
    logic [5:0]  sram_r_addr;
    logic [15:0] sram_r_data;
    logic        sram_w_en;
    logic [5:0]  sram_w_addr;
    logic [15:0] sram_w_data;
    logic        sram_w_mask;

    sram_queue_64x16 dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_bits    (enq_bits),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_bits    (deq_bits),
        .count       (count),
        .sram_r_en   (sram_r_en),
        .sram_r_addr (sram_r_addr),
        .sram_r_data (sram_r_data),
        .sram_w_en   (sram_w_en),
        .sram_w_addr (sram_w_addr),
        .sram_w_data (sram_w_data),
        .sram_w_mask (sram_w_mask)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [64];
    always @(posedge clock) begin
        if (sram_w_en) mem[sram_w_addr] <= sram_w_data;
        if (sram_r_en) sram_r_data <= mem[sram_r_addr];
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          cnt_m = 0;
    int          enq_total = 0;
    logic [15:0] sb [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are set at posedge+1; sample handshakes, advance one clock, check count.
    task automatic tick();
        logic e_f, d_f, fl;
        #1;
        fl  = flush;
        e_f = enq_valid && enq_ready;
        d_f = deq_valid && deq_ready;
        if (!fl) begin
            if (cnt_m < 64)  check_val("enq_ready_free", enq_ready, 1);
            if (cnt_m == 66) check_val("enq_ready_full", enq_ready, 0);
            if (cnt_m == 0)  check_val("deq_valid_empty", deq_valid, 0);
        end
        if (enq_valid) check_val("w_en_vs_fire", sram_w_en, e_f);
        if (d_f) begin
            if (sb.size() != 0) check_val("deq_bits", deq_bits, sb.pop_front());
            else                check_val("deq_spurious", deq_valid, 0);
        end
        if (e_f) begin
            sb.push_back(enq_bits);
            enq_total++;
        end
        @(posedge clock);
        #1;
        if (fl) begin
            sb.delete();
            cnt_m = 0;
        end else begin
            cnt_m += int'(e_f) - int'(d_f);
        end
        check_val("count", count, cnt_m);
    endtask

    task automatic drain(input string tag, input int bound);
        int g;
        g = 0;
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        while (sb.size() != 0 && g < bound) begin
            tick();
            g++;
        end
        check_val(tag, sb.size(), 0);
    endtask

    task automatic enq_n(input string tag, input int n, input logic [15:0] base_val);
        int base, g;
        base = enq_total;
        g = 0;
        enq_valid = 1'b1;
        while (enq_total - base < n && g < 200) begin
            enq_bits = base_val + 16'(enq_total - base);
            tick();
            g++;
        end
        enq_valid = 1'b0;
        check_val(tag, enq_total - base, n);
    endtask

    initial begin
        // Reset values
        #12;
        check_val("rst_enq_ready", enq_ready, 1);
        check_val("rst_deq_valid", deq_valid, 0);
        check_val("rst_count", count, 0);
        check_val("rst_r_en", sram_r_en, 0);
        check_val("rst_w_en", sram_w_en, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Single entry: deq_valid at cycle 3
        enq_valid = 1'b1;
        enq_bits  = 16'hA5A5;
        deq_ready = 1'b1;
        #1;
        check_val("single_w_en", sram_w_en, 1);
        check_val("single_w_addr", sram_w_addr, 0);
        check_val("single_w_data", sram_w_data, 16'hA5A5);
        check_val("single_w_mask", sram_w_mask, 1);
        tick();
        enq_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check_val("single_deq_valid", deq_valid, (c == 3));
            if (c == 1) check_val("single_r_en", sram_r_en, 1);
            tick();
        end

        // Fill to 66 with no dequeue, hold off, then drain in order
        deq_ready = 1'b0;
        enq_n("fill_accepts", 66, 16'h1000);
        enq_valid = 1'b1;
        enq_bits  = 16'hDEAD;
        #1;
        check_val("fill_enq_ready", enq_ready, 0);
        check_val("fill_count", count, 66);
        check_val("fill_w_en_blocked", sram_w_en, 0);
        for (int i = 0; i < 3; i++) tick();
        drain("fill_drain", 200);

        // Streaming 0..199 with deq_ready held high
        deq_ready = 1'b1;
        for (int c = 0; c < 203; c++) begin
            enq_valid = (c < 200);
            enq_bits  = 16'(c);
            #1;
            check_val("stream_deq_valid", deq_valid, (c >= 3));
            tick();
        end
        enq_valid = 1'b0;
        check_val("stream_left", sb.size(), 0);

        // Flush the cycle after a read is issued
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        enq_bits  = 16'hBEEF;
        tick();
        enq_bits  = 16'hCAFE;
        #1;
        check_val("flush_pre_r_en", sram_r_en, 1);
        tick();
        enq_valid = 1'b0;
        flush     = 1'b1;
        #1;
        check_val("flush_r_en", sram_r_en, 0);
        check_val("flush_enq_ready", enq_ready, 0);
        check_val("flush_deq_valid", deq_valid, 0);
        tick();
        flush = 1'b0;
        check_val("flush_post_count", count, 0);
        check_val("flush_post_deq_valid", deq_valid, 0);
        tick();
        tick();
        enq_valid = 1'b1;
        enq_bits  = 16'h1234;
        #1;
        check_val("flush_w_addr", sram_w_addr, 0);
        tick();
        drain("flush_drain", 20);

        // Random traffic with 30% dequeue duty
        for (int i = 0; i < 10000; i++) begin
            enq_valid = 1'($urandom_range(0, 1));
            enq_bits  = 16'($urandom);
            deq_ready = ($urandom_range(0, 99) < 30);
            tick();
        end
        drain("rand_drain", 300);

        // Asynchronous reset with 40 entries held
        deq_ready = 1'b0;
        enq_n("rst_mid_accepts", 40, 16'h4000);
        tick();
        tick();
        check_val("rst_mid_pre_count", count, 40);
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_enq_ready", enq_ready, 1);
        check_val("rst_mid_deq_valid", deq_valid, 0);
        check_val("rst_mid_count", count, 0);
        check_val("rst_mid_r_en", sram_r_en, 0);
        check_val("rst_mid_w_en", sram_w_en, 0);
        sb.delete();
        cnt_m = 0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        enq_valid = 1'b1;
        enq_bits  = 16'h5A5A;
        #1;
        check_val("rst_post_w_addr", sram_w_addr, 0);
        tick();
        drain("rst_post_drain", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
